// File: rtl/par_traffic_if.sv
// par_traffic_if
//     Local injection link between a traffic source and a router port.
//     data  : {dest, payload} offered by the source, dest in the MSBs
//     valid : data holds an offered packet
//     busy  : the router port cannot accept this cycle
//     master modport is the source side, slave modport is the router side.
interface par_traffic_if #(
    parameter int ADDR_BITS    = 4,
    parameter int PAYLOAD_SIZE = 8
);
    logic [ADDR_BITS+PAYLOAD_SIZE-1:0] data;
    logic                              valid;
    logic                              busy;

    modport master (output data, output valid, input busy);
    modport slave  (input data, input valid, output busy);
endinterface

// File: rtl/par_traffic_gen.sv
// par_traffic_gen
//     LFSR-driven synthetic packet source for one NoC node. Supports uniform,
//     transpose, hotspot and neighbour destination patterns, a programmable
//     injection rate and an optional packet budget.
// Ports
//     clk         : rising-edge clock
//     reset       : asynchronous, active-low
//     send        : global generation enable
//     link        : master side of the injection link (data, valid, busy)
//     pkt_count   : packets accepted, wraps at 2^16
//     stall_count : offer cycles with busy=1, saturates at 16'hFFFF
//     done        : packet budget exhausted (terminal until reset)
module par_traffic_gen #(
    parameter int          ID           = 0,
    parameter int          NUM_NODES    = 9,
    parameter int          MESH_X       = 3,
    parameter int          ADDR_BITS    = 4,
    parameter int          PAYLOAD_SIZE = 8,
    parameter int          PIR          = 255,
    parameter int          MODE         = 0,
    parameter int          HOTSPOT      = 0,
    parameter int          HOT_RATE     = 64,
    parameter int          MAX_PACKETS  = 0,
    parameter logic [15:0] SEED         = 16'hACE1
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 send,
    par_traffic_if.master        link,
    output logic [15:0]          pkt_count,
    output logic [15:0]          stall_count,
    output logic                 done
);

    localparam int W = ADDR_BITS + PAYLOAD_SIZE;

    // An all-zero seed would lock the LFSR at zero forever.
    localparam logic [15:0] SEED_EFF = (SEED == 16'h0000) ? 16'h0001 : SEED;
    localparam logic [15:0] MAX16    = 16'(MAX_PACKETS);

    // Fixed destinations, resolved at elaboration time.
    localparam int NEXT_ID = (ID + 1) % NUM_NODES;
    localparam int TR_X    = ID % MESH_X;
    localparam int TR_Y    = ID / MESH_X;
    localparam int TR_T    = TR_X * MESH_X + TR_Y;
    localparam int TR_DEST = ((TR_X == TR_Y) || (TR_T >= NUM_NODES)) ? NEXT_ID : TR_T;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_OFFER = 2'd1,
        S_DONE  = 2'd2
    } state_t;

    state_t         state_q, state_d;
    logic [15:0]    lfsr_q, lfsr_d;
    logic [15:0]    seq_q, seq_d;
    logic [15:0]    pkt_q, pkt_d;
    logic [15:0]    stall_q, stall_d;
    logic [W-1:0]   data_q, data_d;
    logic           inj;
    logic [W-1:0]   pkt_word;

    // 16-bit Galois LFSR, right shift, taps 16'hB400.
    function automatic logic [15:0] lfsr_step(input logic [15:0] s);
        return (s >> 1) ^ (s[0] ? 16'hB400 : 16'h0000);
    endfunction

    function automatic logic [15:0] sat_inc(input logic [15:0] v);
        return (v == 16'hFFFF) ? v : v + 16'd1;
    endfunction

    // Uniform pick that never targets this node itself.
    function automatic int uni_dest(input logic [7:0] r);
        int d;
        d = int'(r) % NUM_NODES;
        if (d == ID) d = NEXT_ID;
        return d;
    endfunction

    function automatic logic [ADDR_BITS-1:0] dest_of(input logic [7:0] r);
        int d;
        if (MODE == 1) begin
            d = TR_DEST;
        end else if (MODE == 2) begin
            d = ((int'(r) < HOT_RATE) && (ID != HOTSPOT)) ? HOTSPOT : uni_dest(r);
        end else if (MODE == 3) begin
            d = NEXT_ID;
        end else begin
            d = uni_dest(r);
        end
        return ADDR_BITS'(d);
    endfunction

    assign inj      = (PIR == 255) || (int'(lfsr_q[7:0]) < PIR);
    assign pkt_word = {dest_of(lfsr_q[15:8]), PAYLOAD_SIZE'(seq_q)};

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= S_IDLE;
            lfsr_q  <= SEED_EFF;
            seq_q   <= 16'd0;
            pkt_q   <= 16'd0;
            stall_q <= 16'd0;
            data_q  <= '0;
        end else begin
            state_q <= state_d;
            lfsr_q  <= lfsr_d;
            seq_q   <= seq_d;
            pkt_q   <= pkt_d;
            stall_q <= stall_d;
            data_q  <= data_d;
        end
    end

    always_comb begin
        state_d = state_q;
        lfsr_d  = lfsr_q;
        seq_d   = seq_q;
        pkt_d   = pkt_q;
        stall_d = stall_q;
        data_d  = data_q;

        // LFSR only moves with send so the pattern is independent of send gaps.
        if (send && (state_q != S_DONE)) lfsr_d = lfsr_step(lfsr_q);

        case (state_q)
            S_IDLE: begin
                if (send && inj) begin
                    data_d  = pkt_word;
                    seq_d   = seq_q + 16'd1;
                    state_d = S_OFFER;
                end
            end
            S_OFFER: begin
                // Offer is held regardless of send until the router takes it.
                if (link.busy) begin
                    stall_d = sat_inc(stall_q);
                end else begin
                    pkt_d = pkt_q + 16'd1;
                    if ((MAX_PACKETS != 0) && (pkt_d == MAX16)) begin
                        state_d = S_DONE;
                    end else if (send && inj) begin
                        data_d = pkt_word;
                        seq_d  = seq_q + 16'd1;
                    end else begin
                        state_d = S_IDLE;
                    end
                end
            end
            S_DONE: begin
                state_d = S_DONE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    assign link.data   = data_q;
    assign link.valid  = (state_q == S_OFFER);
    assign done        = (state_q == S_DONE);
    assign pkt_count   = pkt_q;
    assign stall_count = stall_q;

endmodule

// File: tb/tb_par_traffic_gen.sv
module tb_par_traffic_gen;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst_n, rst_bp_n;
    logic snd_nb, snd_bp, snd_uni, snd_tr, snd_p0, snd_p128;

    logic [15:0] pkt_nb, stall_nb, pkt_bp, stall_bp, pkt_uni, stall_uni;
    logic [15:0] pkt_tr1, stall_tr1, pkt_tr5, stall_tr5, pkt_tr4, stall_tr4;
    logic [15:0] pkt_p0, stall_p0, pkt_p128, stall_p128;
    logic        done_nb, done_bp, done_uni, done_tr1, done_tr5, done_tr4, done_p0, done_p128;

    par_traffic_if #(.ADDR_BITS(4), .PAYLOAD_SIZE(8)) if_nb();
    par_traffic_if #(.ADDR_BITS(4), .PAYLOAD_SIZE(8)) if_bp();
    par_traffic_if #(.ADDR_BITS(4), .PAYLOAD_SIZE(8)) if_uni();
    par_traffic_if #(.ADDR_BITS(4), .PAYLOAD_SIZE(8)) if_tr1();
    par_traffic_if #(.ADDR_BITS(4), .PAYLOAD_SIZE(8)) if_tr5();
    par_traffic_if #(.ADDR_BITS(4), .PAYLOAD_SIZE(8)) if_tr4();
    par_traffic_if #(.ADDR_BITS(4), .PAYLOAD_SIZE(8)) if_p0();
    par_traffic_if #(.ADDR_BITS(4), .PAYLOAD_SIZE(8)) if_p128();

    par_traffic_gen #(.ID(8), .NUM_NODES(9), .MESH_X(3), .ADDR_BITS(4), .PAYLOAD_SIZE(8),
                      .PIR(255), .MODE(3), .MAX_PACKETS(4)) u_nb (
        .clk(clk), .reset(rst_n), .send(snd_nb), .link(if_nb.master),
        .pkt_count(pkt_nb), .stall_count(stall_nb), .done(done_nb));

    par_traffic_gen #(.ID(0), .NUM_NODES(9), .MESH_X(3), .ADDR_BITS(4), .PAYLOAD_SIZE(8),
                      .PIR(255), .MODE(3), .MAX_PACKETS(0)) u_bp (
        .clk(clk), .reset(rst_bp_n), .send(snd_bp), .link(if_bp.master),
        .pkt_count(pkt_bp), .stall_count(stall_bp), .done(done_bp));

    par_traffic_gen #(.ID(4), .NUM_NODES(9), .MESH_X(3), .ADDR_BITS(4), .PAYLOAD_SIZE(8),
                      .PIR(255), .MODE(0), .MAX_PACKETS(0)) u_uni (
        .clk(clk), .reset(rst_n), .send(snd_uni), .link(if_uni.master),
        .pkt_count(pkt_uni), .stall_count(stall_uni), .done(done_uni));

    par_traffic_gen #(.ID(1), .NUM_NODES(9), .MESH_X(3), .ADDR_BITS(4), .PAYLOAD_SIZE(8),
                      .PIR(255), .MODE(1)) u_tr1 (
        .clk(clk), .reset(rst_n), .send(snd_tr), .link(if_tr1.master),
        .pkt_count(pkt_tr1), .stall_count(stall_tr1), .done(done_tr1));

    par_traffic_gen #(.ID(5), .NUM_NODES(9), .MESH_X(3), .ADDR_BITS(4), .PAYLOAD_SIZE(8),
                      .PIR(255), .MODE(1)) u_tr5 (
        .clk(clk), .reset(rst_n), .send(snd_tr), .link(if_tr5.master),
        .pkt_count(pkt_tr5), .stall_count(stall_tr5), .done(done_tr5));

    par_traffic_gen #(.ID(4), .NUM_NODES(9), .MESH_X(3), .ADDR_BITS(4), .PAYLOAD_SIZE(8),
                      .PIR(255), .MODE(1)) u_tr4 (
        .clk(clk), .reset(rst_n), .send(snd_tr), .link(if_tr4.master),
        .pkt_count(pkt_tr4), .stall_count(stall_tr4), .done(done_tr4));

    par_traffic_gen #(.ID(2), .NUM_NODES(9), .MESH_X(3), .ADDR_BITS(4), .PAYLOAD_SIZE(8),
                      .PIR(0), .MODE(0)) u_p0 (
        .clk(clk), .reset(rst_n), .send(snd_p0), .link(if_p0.master),
        .pkt_count(pkt_p0), .stall_count(stall_p0), .done(done_p0));

    par_traffic_gen #(.ID(3), .NUM_NODES(9), .MESH_X(3), .ADDR_BITS(4), .PAYLOAD_SIZE(8),
                      .PIR(128), .MODE(0)) u_p128 (
        .clk(clk), .reset(rst_n), .send(snd_p128), .link(if_p128.master),
        .pkt_count(pkt_p128), .stall_count(stall_p128), .done(done_p128));

    int n_vec  = 0;
    int n_miss = 0;

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_miss++;
            $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    int hist [16];
    int got_uni;
    int n_tr1, n_tr5, n_tr4, bad_tr1, bad_tr5, bad_tr4;
    int v_p0;

    initial begin
        rst_n = 1'b0; rst_bp_n = 1'b0;
        snd_nb = 1'b0; snd_bp = 1'b0; snd_uni = 1'b0; snd_tr = 1'b0; snd_p0 = 1'b0; snd_p128 = 1'b0;
        if_nb.busy = 1'b0; if_bp.busy = 1'b0; if_uni.busy = 1'b0; if_tr1.busy = 1'b0;
        if_tr5.busy = 1'b0; if_tr4.busy = 1'b0; if_p0.busy = 1'b0; if_p128.busy = 1'b0;
        for (int i = 0; i < 16; i++) hist[i] = 0;

        // Reset state
        #12;
        check_val("rst_valid", 32'(if_nb.valid), 32'd0);
        check_val("rst_data",  32'(if_nb.data),  32'd0);
        check_val("rst_pkt",   32'(pkt_nb),      32'd0);
        check_val("rst_stall", 32'(stall_nb),    32'd0);
        check_val("rst_done",  32'(done_nb),     32'd0);
        step();
        rst_n = 1'b1; rst_bp_n = 1'b1;
        step();

        // Neighbour, no back-pressure, budget of 4: ID 8 -> dest 0
        snd_nb = 1'b1;
        step();
        for (int k = 0; k < 4; k++) begin
            check_val($sformatf("nb_valid%0d", k), 32'(if_nb.valid), 32'd1);
            check_val($sformatf("nb_data%0d", k),  32'(if_nb.data),  32'(k));
            step();
        end
        check_val("nb_done",  32'(done_nb),     32'd1);
        check_val("nb_vlow",  32'(if_nb.valid), 32'd0);
        check_val("nb_pkt",   32'(pkt_nb),      32'd4);
        step(); step();
        check_val("nb_done_hold", 32'(done_nb),  32'd1);
        check_val("nb_pkt_hold",  32'(pkt_nb),   32'd4);
        snd_nb = 1'b0;

        // Back-pressure hold: ID 0 -> dest 1
        if_bp.busy = 1'b1;
        snd_bp = 1'b1;
        step();
        for (int i = 0; i < 5; i++) begin
            check_val($sformatf("bp_valid%0d", i), 32'(if_bp.valid), 32'd1);
            check_val($sformatf("bp_data%0d", i),  32'(if_bp.data),  32'h100);
            check_val($sformatf("bp_stall%0d", i), 32'(stall_bp),    32'(i));
            step();
        end
        check_val("bp_stall5", 32'(stall_bp),   32'd5);
        check_val("bp_data5",  32'(if_bp.data), 32'h100);
        check_val("bp_pkt0",   32'(pkt_bp),     32'd0);
        if_bp.busy = 1'b0;
        step();
        check_val("bp_pkt1",   32'(pkt_bp),      32'd1);
        check_val("bp_next",   32'(if_bp.data),  32'h101);
        check_val("bp_vnext",  32'(if_bp.valid), 32'd1);

        // Reset mid-offer, checked before any further clock edge
        if_bp.busy = 1'b1;
        step();
        check_val("rmo_pre_valid", 32'(if_bp.valid), 32'd1);
        rst_bp_n = 1'b0;
        #1;
        check_val("rmo_valid", 32'(if_bp.valid), 32'd0);
        check_val("rmo_pkt",   32'(pkt_bp),      32'd0);
        check_val("rmo_data",  32'(if_bp.data),  32'd0);
        check_val("rmo_stall", 32'(stall_bp),    32'd0);
        step();
        rst_bp_n   = 1'b1;
        if_bp.busy = 1'b0;
        step();
        check_val("rmo_first_valid", 32'(if_bp.valid),      32'd1);
        check_val("rmo_first_pay",   32'(if_bp.data[7:0]),  32'd0);
        snd_bp = 1'b0;

        // Uniform random, ID 4: 1000 packets
        got_uni = 0;
        snd_uni = 1'b1;
        for (int c = 0; c < 1500 && got_uni < 1000; c++) begin
            step();
            if (if_uni.valid) begin
                hist[if_uni.data[11:8]]++;
                got_uni++;
            end
        end
        snd_uni = 1'b0;
        check_val("uni_count", 32'(got_uni), 32'd1000);
        check_val("uni_self",  32'(hist[4]), 32'd0);
        begin
            int oor;
            oor = 0;
            for (int d = 9; d < 16; d++) oor += hist[d];
            check_val("uni_range", 32'(oor), 32'd0);
        end
        for (int d = 0; d < 9; d++) begin
            if (d != 4) check_val($sformatf("uni_min_d%0d", d), 32'(hist[d] >= 60), 32'd1);
        end

        // Transpose on a 3x3 mesh
        n_tr1 = 0; n_tr5 = 0; n_tr4 = 0; bad_tr1 = 0; bad_tr5 = 0; bad_tr4 = 0;
        snd_tr = 1'b1;
        for (int c = 0; c < 20; c++) begin
            step();
            if (if_tr1.valid) begin n_tr1++; if (if_tr1.data[11:8] != 4'd3) bad_tr1++; end
            if (if_tr5.valid) begin n_tr5++; if (if_tr5.data[11:8] != 4'd7) bad_tr5++; end
            if (if_tr4.valid) begin n_tr4++; if (if_tr4.data[11:8] != 4'd5) bad_tr4++; end
        end
        snd_tr = 1'b0;
        check_val("tr1_dest", 32'(bad_tr1), 32'd0);
        check_val("tr5_dest", 32'(bad_tr5), 32'd0);
        check_val("tr4_dest", 32'(bad_tr4), 32'd0);
        check_val("tr1_seen", 32'(n_tr1 >= 15), 32'd1);
        check_val("tr5_seen", 32'(n_tr5 >= 15), 32'd1);
        check_val("tr4_seen", 32'(n_tr4 >= 15), 32'd1);

        // PIR = 0 never offers
        v_p0 = 0;
        snd_p0 = 1'b1;
        repeat (200) begin
            step();
            if (if_p0.valid) v_p0++;
        end
        snd_p0 = 1'b0;
        check_val("p0_valid", 32'(v_p0),   32'd0);
        check_val("p0_pkt",   32'(pkt_p0), 32'd0);

        // PIR = 128 over 4096 cycles
        snd_p128 = 1'b1;
        repeat (4096) step();
        snd_p128 = 1'b0;
        check_val("p128_rate",  32'((pkt_p128 >= 16'd1800) && (pkt_p128 <= 16'd2300)), 32'd1);
        check_val("p128_stall", 32'(stall_p128), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule
